// File: rtl/frame_seq_defs.sv
// rtl/frame_seq_defs.sv - shared state encodings and sequence arithmetic for the frame request handshake
//
// Shared with the capture state machine so both sides agree on how the
// request/acknowledge sequence number wraps.
//   SEQ_W    : width of the mreg / look_for sequence numbers
//   state_t  : encoded request-generator states (visible on oSTATE)
//   seq_inc  : next sequence value, modulo 2**SEQ_W
package frame_seq_defs;

  localparam int SEQ_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_GAP      = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

  function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] value);
    return value + SEQ_W'(1);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - clearable up-counter with terminal-count compare
//
// Ports:
//   clk         : clock, posedge
//   rst         : synchronous active-high reset
//   clear       : zero the count (wins over enable)
//   enable      : advance the count by one
//   terminal    : compare value
//   at_terminal : count equals terminal this cycle
module cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/frame_request_gen.sv
// rtl/frame_request_gen.sv - issues a burst of frame requests to the capture state machine
//
// Ports:
//   CLOCK, RESET : clock (posedge) and synchronous active-high reset
//   file_open    : session enable; low aborts a burst
//   start        : one-cycle burst launch, honoured only in IDLE
//   req_count    : number of requests in the burst (0 = none)
//   look_for     : responder's completed-frame sequence counter
//   mreg         : request sequence value presented to the responder
//   busy         : high outside IDLE
//   frames_done  : acknowledges received in the current burst (saturating)
//   burst_done   : one-cycle pulse at burst end
//   timeout_err  : sticky timeout flag, cleared by the next accepted start
//   oSTATE       : encoded current state
module frame_request_gen
  import frame_seq_defs::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  GAP_CYCLES     = 8'd4,
  parameter int          CNT_W          = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             file_open,
  input  logic             start,
  input  logic [SEQ_W-1:0] req_count,
  input  logic [SEQ_W-1:0] look_for,
  output logic [SEQ_W-1:0] mreg,
  output logic             busy,
  output logic [SEQ_W-1:0] frames_done,
  output logic             burst_done,
  output logic             timeout_err,
  output logic [2:0]       oSTATE
);

  // Terminal values are "cycles - 1" because the counter starts at zero.
  // A zero gap would underflow, so it is treated as a one-cycle gap.
  localparam logic [CNT_W-1:0] TO_TERM  = CNT_W'(TIMEOUT_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0] GAP_TERM = (GAP_CYCLES == 8'd0) ? '0 : CNT_W'(GAP_CYCLES - 8'd1);

  state_t           state;
  state_t           next_state;
  logic [SEQ_W-1:0] mreg_q;
  logic [SEQ_W-1:0] remaining;
  logic [SEQ_W-1:0] frames_q;
  logic             burst_q;
  logic             terr_q;

  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_term;

  logic             ack;
  logic             abort;
  logic             accept;

  assign ack    = (mreg_q == look_for);
  assign abort  = (state != ST_IDLE) && !file_open;
  assign accept = (state == ST_IDLE) && start && file_open;

  assign cnt_term = (state == ST_GAP) ? GAP_TERM : TO_TERM;

  cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk         (CLOCK),
    .rst         (RESET),
    .clear       (cnt_clear),
    .enable      (cnt_en),
    .terminal    (cnt_term),
    .at_terminal (cnt_hit)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (accept && (req_count != '0)) begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_clear  = 1'b1;
        next_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // An acknowledge arriving on the timeout cycle still counts.
        if (ack) begin
          cnt_clear  = 1'b1;
          next_state = (remaining == SEQ_W'(1)) ? ST_FINISH : ST_GAP;
        end else if (cnt_hit) begin
          next_state = ST_FINISH;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_GAP: begin
        cnt_en = 1'b1;
        if (cnt_hit) begin
          next_state = ST_ISSUE;
        end
      end
      ST_FINISH: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    if (abort) begin
      next_state = ST_IDLE;
      cnt_clear  = 1'b1;
      cnt_en     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mreg_q    <= look_for;
      remaining <= '0;
      frames_q  <= '0;
      burst_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      burst_q <= 1'b0;
      if (abort) begin
        // Withdraw any pending request; frames_done keeps its count.
        mreg_q <= look_for;
      end else begin
        case (state)
          ST_IDLE: begin
            mreg_q <= look_for;
            if (accept) begin
              terr_q <= 1'b0;
              if (req_count != '0) begin
                remaining <= req_count;
                frames_q  <= '0;
              end else begin
                burst_q <= 1'b1;
              end
            end
          end
          ST_ISSUE: begin
            mreg_q <= seq_inc(look_for);
          end
          ST_WAIT_ACK: begin
            if (ack) begin
              if (frames_q != '1) begin
                frames_q <= frames_q + SEQ_W'(1);
              end
              remaining <= remaining - SEQ_W'(1);
              if (remaining == SEQ_W'(1)) begin
                burst_q <= 1'b1;
              end
            end else if (cnt_hit) begin
              terr_q  <= 1'b1;
              mreg_q  <= look_for;
              burst_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mreg        = mreg_q;
  assign busy        = (state != ST_IDLE);
  assign frames_done = frames_q;
  assign burst_done  = burst_q;
  assign timeout_err = terr_q;
  assign oSTATE      = state;

endmodule

// File: tb/tb_frame_request_gen.sv
// tb/tb_frame_request_gen.sv - randomized self-checking bench for frame_request_gen
module tb_frame_request_gen;

  localparam int TO  = 100;
  localparam int GAP = 4;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       file_open;
  logic       start;
  logic [7:0] req_count;
  logic [7:0] look_for;
  logic [7:0] mreg;
  logic       busy;
  logic [7:0] frames_done;
  logic       burst_done;
  logic       timeout_err;
  logic [2:0] oSTATE;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  frame_request_gen #(
    .TIMEOUT_CYCLES (16'(TO)),
    .GAP_CYCLES     (8'(GAP)),
    .CNT_W          (16)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .file_open   (file_open),
    .start       (start),
    .req_count   (req_count),
    .look_for    (look_for),
    .mreg        (mreg),
    .busy        (busy),
    .frames_done (frames_done),
    .burst_done  (burst_done),
    .timeout_err (timeout_err),
    .oSTATE      (oSTATE)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  // Runs one burst against a responder model that acknowledges each request
  // delay_mode cycles after it appears (0: random 1..30, <0: never).
  // abort_req : drop file_open in the WAIT_ACK of this request (0 = no abort)
  // reset_ack : pulse RESET in the gap following this acknowledge (0 = none)
  // poke      : fire an extra start while the burst is active
  task automatic run_burst(input logic [7:0] lf0, input logic [7:0] n, input int delay_mode,
                           input int abort_req, input int reset_ack, input bit poke);
    int s, issued, acked, ack_at, to_at, issue_cyc, last_ack;
    int done_exp, end_at, ctl_at, pulses, exp_change, d;
    logic [7:0] prev, exp_val;
    bit done;
    RESET = 1'b0; file_open = 1'b1; start = 1'b0; look_for = lf0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    check("idle_mreg", int'(mreg), int'(lf0));
    check("idle_busy", int'(busy), 0);
    s = cyc;
    start = 1'b1; req_count = n;
    issued = 0; acked = 0; ack_at = -1; to_at = -1; issue_cyc = -1; last_ack = -1;
    done_exp = -1; end_at = -1; ctl_at = -1; pulses = 0; exp_change = s + 2;
    prev = lf0; done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge CLOCK);
      start = 1'b0;
      if (cyc == ctl_at) begin
        check("ctl_busy", int'(busy), 0);
        check("ctl_mreg", int'(mreg), int'(look_for));
        check("ctl_pulse", int'(burst_done), 0);
        check("ctl_state", int'(oSTATE), 0);
        check("ctl_frames", int'(frames_done), (reset_ack != 0) ? 0 : abort_req - 1);
        RESET = 1'b0; file_open = 1'b1; done = 1'b1;
      end else if (cyc == end_at) begin
        check("end_busy", int'(busy), 0);
        check("end_pulse", int'(burst_done), 0);
        check("end_frames", int'(frames_done), acked);
        check("end_terr", int'(timeout_err), (delay_mode < 0) ? 1 : 0);
        check("end_mreg", int'(mreg), int'(look_for));
        check("end_issued", issued, (delay_mode < 0) ? 1 : int'(n));
        check("end_pulses", pulses, 1);
        done = 1'b1;
      end else begin
        if (burst_done) begin
          pulses++;
          check("done_time", cyc, done_exp);
          end_at = cyc + 1;
        end
        if (delay_mode < 0 && cyc == to_at) begin
          check("to_flag", int'(timeout_err), 1);
          check("to_mreg", int'(mreg), int'(look_for));
          check("to_pulse", int'(burst_done), 1);
        end
        if (mreg != prev && mreg != look_for) begin
          issued++;
          exp_val = lf0 + 8'(issued);
          check("req_value", int'(mreg), int'(exp_val));
          check("req_time", cyc, exp_change);
          issue_cyc = cyc;
          to_at = cyc + TO;
          d = (delay_mode > 0) ? delay_mode : int'($urandom_range(1, 30));
          ack_at = (delay_mode < 0) ? -1 : cyc + d;
          if (delay_mode < 0) done_exp = to_at;
        end
        prev = mreg;
        if (cyc == ack_at) begin
          look_for = mreg;
          acked++;
          last_ack = cyc;
          exp_change = cyc + GAP + 2;
          if (acked == int'(n)) done_exp = cyc + 1;
        end
        if (poke && issued == 1 && cyc == issue_cyc + 1) begin
          start = 1'b1;
          req_count = n + 8'd5;
        end
        if (abort_req != 0 && issued == abort_req && cyc == issue_cyc + 3 && ctl_at < 0) begin
          file_open = 1'b0;
          ctl_at = cyc + 1;
        end
        if (reset_ack != 0 && acked == reset_ack && cyc == last_ack + 2 && ctl_at < 0) begin
          check("gap_state", int'(oSTATE), 3);
          RESET = 1'b1;
          ctl_at = cyc + 1;
        end
      end
    end
    if (!done) check("burst_bound", 0, 1);
    RESET = 1'b0; file_open = 1'b1; start = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    RESET = 1'b1; file_open = 1'b0; start = 1'b0; req_count = 8'd0; look_for = 8'h5A;
    @(negedge CLOCK);
    @(negedge CLOCK);
    check("rst_mreg", int'(mreg), 8'h5A);
    check("rst_busy", int'(busy), 0);
    check("rst_frames", int'(frames_done), 0);
    check("rst_pulse", int'(burst_done), 0);
    check("rst_terr", int'(timeout_err), 0);
    check("rst_state", int'(oSTATE), 0);
    RESET = 1'b0;
    file_open = 1'b1;

    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      look_for = v;
      @(negedge CLOCK);
      check("idle_follow", int'(mreg), int'(v));
      check("idle_follow_busy", int'(busy), 0);
    end

    run_burst(8'h10, 8'd3, 20, 0, 0, 1'b0);
    run_burst(8'hFE, 8'd3, 0, 0, 0, 1'b0);
    run_burst(8'h40, 8'd1, -1, 0, 0, 1'b0);
    run_burst(8'h80, 8'd3, 20, 2, 0, 1'b0);

    look_for = 8'h77;
    @(negedge CLOCK);
    @(negedge CLOCK);
    start = 1'b1; req_count = 8'd0;
    @(negedge CLOCK);
    start = 1'b0;
    check("zero_pulse", int'(burst_done), 1);
    check("zero_busy", int'(busy), 0);
    check("zero_mreg", int'(mreg), 8'h77);
    @(negedge CLOCK);
    check("zero_pulse_end", int'(burst_done), 0);
    check("zero_mreg_hold", int'(mreg), 8'h77);

    run_burst(8'h22, 8'd3, 0, 0, 0, 1'b1);
    run_burst(8'h30, 8'd3, 20, 0, 1, 1'b0);
    run_burst(8'h31, 8'd2, 0, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_burst(8'($urandom), 8'($urandom_range(1, 4)), 0, 0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
